// File: rtl/intr_ctrl.sv
// Single-level vectored interrupt controller: edge-detects 4 irq lines, services the lowest enabled index.
// ENTER one cycle after the pending bit sets; no backpressure, the FSM drives one-cycle strobes only.
module intr_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  irq,
    input  logic        mask_we,
    input  logic [3:0]  mask_din,
    input  logic        reti,
    input  logic [9:0]  pc,
    output logic        push,
    output logic        pop,
    output logic        s_intr,
    output logic [9:0]  stk_dato,
    output logic        pc_load,
    output logic [9:0]  pc_vector,
    output logic        pc_ret,
    output logic        in_isr,
    output logic [3:0]  ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTER = 2'd1,
        ISR   = 2'd2,
        EXIT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  irq_q;
    logic [3:0]  pending;
    logic [3:0]  mask;
    logic [3:0]  rise;
    logic [3:0]  eligible;
    logic [3:0]  clr;
    logic [1:0]  sel;
    logic [1:0]  sel_nxt;
    logic [9:0]  save_pc;
    logic        take;

    assign rise     = irq & ~irq_q;
    assign eligible = pending & mask;

    // Scan from the top so the lowest eligible index wins.
    always_comb begin
        sel_nxt = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_nxt = 2'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        pop       = 1'b0;
        s_intr    = 1'b0;
        stk_dato  = 10'h000;
        pc_load   = 1'b0;
        pc_vector = 10'h000;
        pc_ret    = 1'b0;
        in_isr    = 1'b0;
        ack       = 4'b0000;
        clr       = 4'b0000;
        case (state)
            IDLE: begin
                if ((eligible != 4'b0000) && !reti) begin
                    state_nxt = ENTER;
                end
            end
            ENTER: begin
                push      = 1'b1;
                stk_dato  = save_pc;
                pc_load   = 1'b1;
                pc_vector = 10'h3C0 + {4'b0000, sel, 4'b0000};
                ack       = 4'b0001 << sel;
                clr       = 4'b0001 << sel;
                state_nxt = ISR;
            end
            ISR: begin
                in_isr = 1'b1;
                if (reti) begin
                    state_nxt = EXIT;
                end
            end
            EXIT: begin
                s_intr    = 1'b1;
                pc_ret    = 1'b1;
                pop       = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign take = (state == IDLE) && (state_nxt == ENTER);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            irq_q   <= 4'b0000;
            pending <= 4'b0000;
            mask    <= 4'b0000;
            sel     <= 2'd0;
            save_pc <= 10'h000;
        end else begin
            state   <= state_nxt;
            irq_q   <= irq;
            // A fresh edge on the line being acknowledged must survive its clear.
            pending <= (pending & ~clr) | rise;
            if (mask_we) begin
                mask <= mask_din;
            end
            if (take) begin
                sel     <= sel_nxt;
                save_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_intr_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  irq = 4'b0000;
    logic        mask_we = 1'b0;
    logic [3:0]  mask_din = 4'b0000;
    logic        reti = 1'b0;
    logic [9:0]  pc = 10'h000;
    logic        push;
    logic        pop;
    logic        s_intr;
    logic [9:0]  stk_dato;
    logic        pc_load;
    logic [9:0]  pc_vector;
    logic        pc_ret;
    logic        in_isr;
    logic [3:0]  ack;

    int passed = 0;
    int total  = 0;

    intr_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .irq       (irq),
        .mask_we   (mask_we),
        .mask_din  (mask_din),
        .reti      (reti),
        .pc        (pc),
        .push      (push),
        .pop       (pop),
        .s_intr    (s_intr),
        .stk_dato  (stk_dato),
        .pc_load   (pc_load),
        .pc_vector (pc_vector),
        .pc_ret    (pc_ret),
        .in_isr    (in_isr),
        .ack       (ack)
    );

    always #5 clk = ~clk;

    // Output bundle: {push,pop,s_intr,stk_dato,pc_load,pc_vector,pc_ret,in_isr,ack}
    logic [29:0] obs;
    assign obs = {push, pop, s_intr, stk_dato, pc_load, pc_vector, pc_ret, in_isr, ack};

    localparam logic [29:0] E_IDLE = 30'h0;
    localparam logic [29:0] E_ISR  = {1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 4'b0000};
    localparam logic [29:0] E_EXIT = {1'b0, 1'b1, 1'b1, 10'h000, 1'b0, 10'h000, 1'b1, 1'b0, 4'b0000};

    function automatic logic [29:0] e_enter(input logic [9:0] spc, input logic [9:0] vec, input logic [3:0] a);
        return {1'b1, 1'b0, 1'b0, spc, 1'b1, vec, 1'b0, 1'b0, a};
    endfunction

    task automatic test_reset();
        irq = 4'hF;
        @(negedge clk);
        total++; if (obs !== E_IDLE) $display("FAIL reset_held_a: got %h expected %h", obs, E_IDLE); else passed++;
        @(negedge clk);
        total++; if (obs !== E_IDLE) $display("FAIL reset_held_b: got %h expected %h", obs, E_IDLE); else passed++;
        irq = 4'h0;
        reset = 1'b0;
        @(negedge clk);
        total++; if (obs !== E_IDLE) $display("FAIL reset_release: got %h expected %h", obs, E_IDLE); else passed++;
    endtask

    task automatic test_enable();
        mask_we = 1'b1; mask_din = 4'b0010; pc = 10'h025;
        @(negedge clk);
        mask_we = 1'b0; irq = 4'b0010;
        @(negedge clk);
        irq = 4'b0000;
        total++; if (obs !== E_IDLE) $display("FAIL en_pending_idle: got %h expected %h", obs, E_IDLE); else passed++;
        @(negedge clk);
        total++; if (obs !== e_enter(10'h025, 10'h3D0, 4'b0010)) $display("FAIL en_enter: got %h expected %h", obs, e_enter(10'h025, 10'h3D0, 4'b0010)); else passed++;
        @(negedge clk);
        total++; if (obs !== E_ISR) $display("FAIL en_isr: got %h expected %h", obs, E_ISR); else passed++;
        @(negedge clk);
        total++; if (obs !== E_ISR) $display("FAIL en_isr_hold: got %h expected %h", obs, E_ISR); else passed++;
    endtask

    task automatic test_return();
        reti = 1'b1;
        @(negedge clk);
        reti = 1'b0;
        total++; if (obs !== E_EXIT) $display("FAIL ret_exit: got %h expected %h", obs, E_EXIT); else passed++;
        @(negedge clk);
        total++; if (obs !== E_IDLE) $display("FAIL ret_idle: got %h expected %h", obs, E_IDLE); else passed++;
        @(negedge clk);
        total++; if (obs !== E_IDLE) $display("FAIL ret_idle_hold: got %h expected %h", obs, E_IDLE); else passed++;
    endtask

    task automatic test_priority();
        mask_we = 1'b1; mask_din = 4'hF; pc = 10'h111;
        @(negedge clk);
        mask_we = 1'b0; irq = 4'b1001;
        @(negedge clk);
        irq = 4'b0000;
        total++; if (obs !== E_IDLE) $display("FAIL pri_idle: got %h expected %h", obs, E_IDLE); else passed++;
        @(negedge clk);
        total++; if (obs !== e_enter(10'h111, 10'h3C0, 4'b0001)) $display("FAIL pri_enter0: got %h expected %h", obs, e_enter(10'h111, 10'h3C0, 4'b0001)); else passed++;
        @(negedge clk);
        total++; if (obs !== E_ISR) $display("FAIL pri_isr0: got %h expected %h", obs, E_ISR); else passed++;
        reti = 1'b1;
        @(negedge clk);
        reti = 1'b0;
        total++; if (obs !== E_EXIT) $display("FAIL pri_exit0: got %h expected %h", obs, E_EXIT); else passed++;
        @(negedge clk);
        pc = 10'h222;
        total++; if (obs !== E_IDLE) $display("FAIL pri_gap: got %h expected %h", obs, E_IDLE); else passed++;
        @(negedge clk);
        total++; if (obs !== e_enter(10'h222, 10'h3F0, 4'b1000)) $display("FAIL pri_enter3: got %h expected %h", obs, e_enter(10'h222, 10'h3F0, 4'b1000)); else passed++;
        @(negedge clk);
        reti = 1'b1;
        @(negedge clk);
        reti = 1'b0;
        total++; if (obs !== E_EXIT) $display("FAIL pri_exit3: got %h expected %h", obs, E_EXIT); else passed++;
        @(negedge clk);
        total++; if (obs !== E_IDLE) $display("FAIL pri_done: got %h expected %h", obs, E_IDLE); else passed++;
    endtask

    task automatic test_mask_ignore();
        mask_we = 1'b1; mask_din = 4'b0000;
        @(negedge clk);
        mask_we = 1'b0; irq = 4'b0100; pc = 10'h0AB;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            irq = 4'b0000;
            total++; if (obs !== E_IDLE) $display("FAIL msk_blocked%0d: got %h expected %h", i, obs, E_IDLE); else passed++;
        end
        mask_we = 1'b1; mask_din = 4'b0100;
        @(negedge clk);
        mask_we = 1'b0;
        total++; if (obs !== E_IDLE) $display("FAIL msk_wr_idle: got %h expected %h", obs, E_IDLE); else passed++;
        @(negedge clk);
        total++; if (obs !== e_enter(10'h0AB, 10'h3E0, 4'b0100)) $display("FAIL msk_enter: got %h expected %h", obs, e_enter(10'h0AB, 10'h3E0, 4'b0100)); else passed++;
        reti = 1'b1;
        @(negedge clk);
        reti = 1'b0;
        total++; if (obs !== E_ISR) $display("FAIL msk_reti_in_enter: got %h expected %h", obs, E_ISR); else passed++;
        reti = 1'b1;
        @(negedge clk);
        reti = 1'b0;
        total++; if (obs !== E_EXIT) $display("FAIL msk_exit: got %h expected %h", obs, E_EXIT); else passed++;
        @(negedge clk);
        reti = 1'b1;
        total++; if (obs !== E_IDLE) $display("FAIL msk_idle: got %h expected %h", obs, E_IDLE); else passed++;
        @(negedge clk);
        reti = 1'b0;
        total++; if (obs !== E_IDLE) $display("FAIL msk_reti_idle: got %h expected %h", obs, E_IDLE); else passed++;
        @(negedge clk);
        total++; if (obs !== E_IDLE) $display("FAIL msk_reti_idle2: got %h expected %h", obs, E_IDLE); else passed++;
    endtask

    task automatic test_abort();
        pc = 10'h155; irq = 4'b0100;
        @(negedge clk);
        irq = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        total++; if (obs !== E_ISR) $display("FAIL abt_isr: got %h expected %h", obs, E_ISR); else passed++;
        reset = 1'b1;
        #1;
        total++; if (obs !== E_IDLE) $display("FAIL abt_immediate: got %h expected %h", obs, E_IDLE); else passed++;
        @(negedge clk);
        total++; if (obs !== E_IDLE) $display("FAIL abt_held: got %h expected %h", obs, E_IDLE); else passed++;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (obs !== E_IDLE) $display("FAIL abt_after%0d: got %h expected %h", i, obs, E_IDLE); else passed++;
        end
        mask_we = 1'b1; mask_din = 4'hF;
        @(negedge clk);
        mask_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (obs !== E_IDLE) $display("FAIL abt_no_pending%0d: got %h expected %h", i, obs, E_IDLE); else passed++;
        end
    endtask

    task automatic test_reset_edge();
        reset = 1'b1; irq = 4'b0001; pc = 10'h3AA;
        @(negedge clk);
        reset = 1'b0; mask_we = 1'b1; mask_din = 4'b0001;
        @(negedge clk);
        mask_we = 1'b0;
        total++; if (obs !== E_IDLE) $display("FAIL rse_idle: got %h expected %h", obs, E_IDLE); else passed++;
        @(negedge clk);
        irq = 4'b0000;
        total++; if (obs !== e_enter(10'h3AA, 10'h3C0, 4'b0001)) $display("FAIL rse_enter: got %h expected %h", obs, e_enter(10'h3AA, 10'h3C0, 4'b0001)); else passed++;
        @(negedge clk);
        reti = 1'b1;
        @(negedge clk);
        reti = 1'b0;
        total++; if (obs !== E_EXIT) $display("FAIL rse_exit: got %h expected %h", obs, E_EXIT); else passed++;
        @(negedge clk);
    endtask

    task automatic test_coincident();
        mask_we = 1'b1; mask_din = 4'hF; pc = 10'h0F0;
        @(negedge clk);
        mask_we = 1'b0; irq = 4'b0010;
        @(negedge clk);
        irq = 4'b0000;
        total++; if (obs !== E_IDLE) $display("FAIL coin_idle: got %h expected %h", obs, E_IDLE); else passed++;
        @(negedge clk);
        irq = 4'b0010;
        total++; if (obs !== e_enter(10'h0F0, 10'h3D0, 4'b0010)) $display("FAIL coin_enter1: got %h expected %h", obs, e_enter(10'h0F0, 10'h3D0, 4'b0010)); else passed++;
        @(negedge clk);
        irq = 4'b0000;
        total++; if (obs !== E_ISR) $display("FAIL coin_isr1: got %h expected %h", obs, E_ISR); else passed++;
        reti = 1'b1;
        @(negedge clk);
        reti = 1'b0;
        total++; if (obs !== E_EXIT) $display("FAIL coin_exit1: got %h expected %h", obs, E_EXIT); else passed++;
        @(negedge clk);
        pc = 10'h0F1;
        total++; if (obs !== E_IDLE) $display("FAIL coin_gap: got %h expected %h", obs, E_IDLE); else passed++;
        @(negedge clk);
        total++; if (obs !== e_enter(10'h0F1, 10'h3D0, 4'b0010)) $display("FAIL coin_enter2: got %h expected %h", obs, e_enter(10'h0F1, 10'h3D0, 4'b0010)); else passed++;
        @(negedge clk);
        reti = 1'b1;
        @(negedge clk);
        reti = 1'b0;
        total++; if (obs !== E_EXIT) $display("FAIL coin_exit2: got %h expected %h", obs, E_EXIT); else passed++;
        @(negedge clk);
        @(negedge clk);
        total++; if (obs !== E_IDLE) $display("FAIL coin_no_third: got %h expected %h", obs, E_IDLE); else passed++;
    endtask

    initial begin
        test_reset();
        test_enable();
        test_return();
        test_priority();
        test_mask_ignore();
        test_abort();
        test_reset_edge();
        test_coincident();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
